// File: rtl/ram_fifo_ctrl.sv
// FIFO controller wrapping an external single-port-per-direction synchronous RAM.
// Pointers, occupancy, sticky error flags and a one-cycle pop_data strobe.
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_pop_data,
  output logic                  o_pop_valid,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_underflow,
  output logic [DATA_WIDTH-1:0] o_ram_data_in,
  output logic [ADDR_WIDTH-1:0] o_ram_wr_address,
  output logic                  o_ram_write,
  output logic [ADDR_WIDTH-1:0] o_ram_rd_address,
  output logic                  o_ram_read,
  input  logic [DATA_WIDTH-1:0] i_ram_data_out
);

  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  r_pop_valid;
  logic [DATA_WIDTH-1:0] r_pop_hold;

  logic                  w_push_acc;
  logic                  w_pop_acc;
  logic [ADDR_WIDTH:0]   w_count_next;

  // Flags are registered, so an accepted pop never frees room for a same-cycle push.
  always_comb begin
    w_push_acc = i_push & ~r_full & ~i_reset;
    w_pop_acc  = i_pop & ~r_empty & ~i_reset;
  end

  always_comb begin
    w_count_next = r_count;
    unique case ({w_push_acc, w_pop_acc})
      2'b10:   w_count_next = r_count + CNT_ONE;
      2'b01:   w_count_next = r_count - CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_pop_valid <= 1'b0;
      r_pop_hold  <= '0;
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count     <= w_count_next;
      r_full      <= (w_count_next == FULL_COUNT);
      r_empty     <= (w_count_next == '0);
      if (i_push && r_full)  r_overflow  <= 1'b1;
      if (i_pop && r_empty)  r_underflow <= 1'b1;
      r_pop_valid <= w_pop_acc;
      if (r_pop_valid) r_pop_hold <= i_ram_data_out;
    end
  end

  // The RAM's output register is the capture stage; r_pop_hold keeps the word afterwards.
  always_comb begin
    o_pop_data       = r_pop_valid ? i_ram_data_out : r_pop_hold;
    o_pop_valid      = r_pop_valid;
    o_full           = r_full;
    o_empty          = r_empty;
    o_count          = r_count;
    o_overflow       = r_overflow;
    o_underflow      = r_underflow;
    o_ram_data_in    = i_push_data;
    o_ram_wr_address = r_wr_ptr;
    o_ram_write      = w_push_acc;
    o_ram_rd_address = r_rd_ptr;
    o_ram_read       = w_pop_acc;
  end

endmodule
